// File: rtl/point_mul_windowed_if.sv
// Start/busy/done handshake bundle for point_mul_windowed: operands in, result and status out.
interface point_mul_windowed_if #(
   parameter int SCALAR_W = 256,
   parameter int COORD_W  = 16
);
   typedef struct packed {
      logic               inf;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } point_t;

   logic                start;
   point_t              P;
   logic [SCALAR_W-1:0] k;
   logic                busy;
   logic                done;
   point_t              R;

   modport master (output start, P, k, input busy, done, R);
   modport slave  (input start, P, k, output busy, done, R);
endinterface

// File: rtl/point_mul_windowed.sv
// point_mul_windowed: MSB-first fixed-window scalar multiplier R = k*P over a precomputed table.
// Optional macro PMUL_SKIP_LEADING_ZERO_EN bypasses doubling while the accumulator is still infinity.

// Points are packed {inf, x, y}; the group law here adds coordinates modulo MODULUS, inf is identity.
module point_add #(
   parameter int COORD_W = 16,
   parameter int MODULUS = 65521,
   parameter int LAT     = 1
) (
   input  logic               clk,
   input  logic               Reset,
   input  logic [2*COORD_W:0] a,
   input  logic [2*COORD_W:0] b,
   output logic [2*COORD_W:0] q,
   output logic               Done
);
   localparam int CW = $clog2(LAT + 1);

   function automatic logic [COORD_W-1:0] mod_add(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y);
      logic [COORD_W:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= (COORD_W+1)'(MODULUS)) s = s - (COORD_W+1)'(MODULUS);
      return s[COORD_W-1:0];
   endfunction

   function automatic logic [2*COORD_W:0] padd(input logic [2*COORD_W:0] u,
                                                input logic [2*COORD_W:0] v);
      if (u[2*COORD_W]) return v;
      if (v[2*COORD_W]) return u;
      return {1'b0, mod_add(u[2*COORD_W-1:COORD_W], v[2*COORD_W-1:COORD_W]),
                    mod_add(u[COORD_W-1:0], v[COORD_W-1:0])};
   endfunction

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (Reset) begin
         q    <= padd(a, b);
         cnt  <= CW'(LAT - 1);
         Done <= (LAT == 1);
      end else if (cnt != '0) begin
         cnt  <= cnt - 1'b1;
         Done <= (cnt == CW'(1));
      end
   end
endmodule

module point_double #(
   parameter int COORD_W = 16,
   parameter int MODULUS = 65521,
   parameter int LAT     = 1
) (
   input  logic               clk,
   input  logic               Reset,
   input  logic [2*COORD_W:0] a,
   output logic [2*COORD_W:0] q,
   output logic               Done
);
   localparam int CW = $clog2(LAT + 1);

   function automatic logic [COORD_W-1:0] mod_dbl(input logic [COORD_W-1:0] x);
      logic [COORD_W:0] s;
      s = {x, 1'b0};
      if (s >= (COORD_W+1)'(MODULUS)) s = s - (COORD_W+1)'(MODULUS);
      return s[COORD_W-1:0];
   endfunction

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (Reset) begin
         q    <= a[2*COORD_W] ? a : {1'b0, mod_dbl(a[2*COORD_W-1:COORD_W]), mod_dbl(a[COORD_W-1:0])};
         cnt  <= CW'(LAT - 1);
         Done <= (LAT == 1);
      end else if (cnt != '0) begin
         cnt  <= cnt - 1'b1;
         Done <= (cnt == CW'(1));
      end
   end
endmodule

module point_mul_windowed #(
   parameter int SCALAR_W = 256,
   parameter int WIN_W    = 4,
   parameter int COORD_W  = 16,
   parameter int MODULUS  = 65521,
   parameter int LAT_ADD  = 1,
   parameter int LAT_DBL  = 1
) (
   input logic                 clk,
   input logic                 Reset_n,
   point_mul_windowed_if.slave bus
);
   localparam int NWIN   = (SCALAR_W + WIN_W - 1) / WIN_W;
   localparam int KEXT   = NWIN * WIN_W;
   localparam int TSIZE  = 1 << WIN_W;
   localparam int PW     = 2 * COORD_W + 1;
   localparam int WIN_IW = $clog2(NWIN + 1);
   localparam int DC_W   = $clog2(WIN_W + 1);

   typedef logic [PW-1:0] pt_t;
   localparam pt_t INF = {1'b1, {(2*COORD_W){1'b0}}};
   localparam logic [WIN_W-1:0]  T_FIRST  = WIN_W'(2);
   localparam logic [WIN_W-1:0]  T_LAST   = WIN_W'(TSIZE - 1);
   localparam logic [WIN_IW-1:0] WIN_LAST = WIN_IW'(NWIN - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_PRE_L, S_PRE_W, S_DIG, S_DBL_L, S_DBL_W, S_ADD_L, S_ADD_W, S_NEXT, S_FINISH
   } state_t;

   state_t              state, state_nx;
   pt_t                 p_cap, acc, r_q;
   logic [KEXT-1:0]     k_cap;
   pt_t                 tbl [TSIZE];
   logic [WIN_IW-1:0]   win;
   logic [WIN_W-1:0]    digit, cur_digit, tidx, tidx_m1;
   logic [DC_W-1:0]     dcnt;
   logic                done_q;
   logic                k_nonzero, pre_dbl, pre_ok;

   logic dbl_launch, add_launch, dbl_rst, add_rst, dbl_done, add_done;
   pt_t  dbl_a, add_a, add_b, dbl_q, add_q;

   assign cur_digit = k_cap[int'(win) * WIN_W +: WIN_W];
   assign tidx_m1   = tidx - 1'b1;
   assign k_nonzero = |bus.k;
   assign pre_dbl   = (tidx == T_FIRST);
   assign pre_ok    = pre_dbl ? dbl_done : add_done;

   // Submodule Reset doubles as the launch pulse and is parked high whenever idle.
   assign dbl_rst = ~Reset_n | (state == S_IDLE) | dbl_launch;
   assign add_rst = ~Reset_n | (state == S_IDLE) | add_launch;

   point_double #(.COORD_W(COORD_W), .MODULUS(MODULUS), .LAT(LAT_DBL)) u_dbl (
      .clk(clk), .Reset(dbl_rst), .a(dbl_a), .q(dbl_q), .Done(dbl_done));

   point_add #(.COORD_W(COORD_W), .MODULUS(MODULUS), .LAT(LAT_ADD)) u_add (
      .clk(clk), .Reset(add_rst), .a(add_a), .b(add_b), .q(add_q), .Done(add_done));

   always_comb begin
      state_nx   = state;
      dbl_launch = 1'b0;
      add_launch = 1'b0;
      dbl_a      = acc;
      add_a      = acc;
      add_b      = tbl[digit];
      case (state)
         S_IDLE:   if (bus.start) state_nx = k_nonzero ? S_PRE_L : S_FINISH;
         S_PRE_L: begin
            if (pre_dbl) begin
               dbl_launch = 1'b1;
               dbl_a      = tbl[1];
            end else begin
               add_launch = 1'b1;
               add_a      = tbl[tidx_m1];
               add_b      = p_cap;
            end
            state_nx = S_PRE_W;
         end
         S_PRE_W:  if (pre_ok) state_nx = (tidx == T_LAST) ? S_DIG : S_PRE_L;
         S_DIG: begin
`ifdef PMUL_SKIP_LEADING_ZERO_EN
            state_nx = acc[PW-1] ? S_NEXT : S_DBL_L;
`else
            state_nx = S_DBL_L;
`endif
         end
         S_DBL_L: begin
            dbl_launch = 1'b1;
            state_nx   = S_DBL_W;
         end
         S_DBL_W: begin
            if (dbl_done) begin
               if (dcnt == DC_W'(1)) state_nx = (digit != '0) ? S_ADD_L : S_NEXT;
               else                  state_nx = S_DBL_L;
            end
         end
         S_ADD_L: begin
            add_launch = 1'b1;
            state_nx   = S_ADD_W;
         end
         S_ADD_W:  if (add_done) state_nx = S_NEXT;
         S_NEXT:   state_nx = (win == '0) ? S_FINISH : S_DIG;
         S_FINISH: state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // Control: state, counters and the visible result.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state  <= S_IDLE;
         done_q <= 1'b0;
         r_q    <= INF;
         win    <= '0;
         tidx   <= '0;
         dcnt   <= '0;
      end else begin
         state  <= state_nx;
         done_q <= (state == S_FINISH);
         case (state)
            S_IDLE: if (bus.start) begin
               win  <= WIN_LAST;
               tidx <= T_FIRST;
            end
            S_PRE_W:  if (pre_ok && tidx != T_LAST) tidx <= tidx + 1'b1;
            S_DIG:    dcnt <= DC_W'(WIN_W);
            S_DBL_W:  if (dbl_done) dcnt <= dcnt - 1'b1;
            S_NEXT:   if (win != '0) win <= win - 1'b1;
            S_FINISH: r_q <= acc;
            default: ;
         endcase
      end
   end

   // Data: captured operands, table and accumulator.
   always_ff @(posedge clk) begin
      case (state)
         S_IDLE: if (bus.start) begin
            p_cap  <= bus.P;
            k_cap  <= KEXT'(bus.k);
            tbl[0] <= INF;
            tbl[1] <= bus.P;
            acc    <= INF;
         end
         S_PRE_W: begin
            if (pre_dbl && dbl_done)       tbl[T_FIRST] <= dbl_q;
            else if (!pre_dbl && add_done) tbl[tidx]    <= add_q;
         end
         S_DIG: begin
            digit <= cur_digit;
`ifdef PMUL_SKIP_LEADING_ZERO_EN
            if (acc[PW-1] && cur_digit != '0) acc <= tbl[cur_digit];
`endif
         end
         S_DBL_W: if (dbl_done) acc <= dbl_q;
         S_ADD_W: if (add_done) acc <= add_q;
         default: ;
      endcase
   end

   assign bus.busy = (state != S_IDLE);
   assign bus.done = done_q;
   assign bus.R    = r_q;
endmodule

// File: tb/tb_point_mul_windowed.sv
// Directed bench for point_mul_windowed: WIN_W=4 and WIN_W=3 instances against a bitwise golden model.
module tb_point_mul_windowed;
   localparam int SW  = 256;
   localparam int CW  = 16;
   localparam int MOD = 65521;
   localparam int PW  = 2 * CW + 1;
   typedef logic [PW-1:0] pt_v;
   localparam pt_v INF = {1'b1, {(2*CW){1'b0}}};

   logic clk = 1'b0;
   logic Reset_n = 1'b0;
   always #5 clk = ~clk;

   point_mul_windowed_if #(.SCALAR_W(SW), .COORD_W(CW)) bus4 ();
   point_mul_windowed_if #(.SCALAR_W(SW), .COORD_W(CW)) bus3 ();

   point_mul_windowed #(.SCALAR_W(SW), .WIN_W(4), .COORD_W(CW), .MODULUS(MOD)) dut (
      .clk(clk), .Reset_n(Reset_n), .bus(bus4));
   point_mul_windowed #(.SCALAR_W(SW), .WIN_W(3), .COORD_W(CW), .MODULUS(MOD)) dut3 (
      .clk(clk), .Reset_n(Reset_n), .bus(bus3));

   int n_checks = 0;
   int n_fail   = 0;
   int dbl_cnt  = 0;
   int add_cnt  = 0;

   always @(posedge clk) begin
      if (dut.dbl_launch) dbl_cnt <= dbl_cnt + 1;
      if (dut.add_launch) add_cnt <= add_cnt + 1;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic pt_v mkpt(input int x, input int y);
      return {1'b0, CW'(x), CW'(y)};
   endfunction

   function automatic logic [CW-1:0] gmul(input logic [SW-1:0] k, input logic [CW-1:0] x);
      int a;
      a = 0;
      for (int i = SW - 1; i >= 0; i--) begin
         a = (a * 2) % MOD;
         if (k[i]) a = (a + int'(x)) % MOD;
      end
      return CW'(a);
   endfunction

   function automatic pt_v golden(input logic [SW-1:0] k, input pt_v p);
      if (k == '0 || p[PW-1]) return INF;
      return {1'b0, gmul(k, p[2*CW-1:CW]), gmul(k, p[CW-1:0])};
   endfunction

   function automatic logic [SW-1:0] rand_k();
      logic [SW-1:0] v;
      for (int i = 0; i < SW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic set_in(input int sel, input bit s, input pt_v p, input logic [SW-1:0] k);
      if (sel == 3) begin
         bus3.start = s; bus3.P = p; bus3.k = k;
      end else begin
         bus4.start = s; bus4.P = p; bus4.k = k;
      end
   endtask

   task automatic run_op(input int sel, input pt_v p, input logic [SW-1:0] k,
                         output pt_v r, output int lat, output bit timeout, output bit pulse1);
      bit   seen;
      logic d;
      set_in(sel, 1'b1, p, k);
      @(negedge clk);
      set_in(sel, 1'b0, p, k);
      lat = 1; seen = 0; timeout = 0; pulse1 = 0; r = INF;
      while (!seen && lat < 6000) begin
         d = (sel == 3) ? bus3.done : bus4.done;
         if (d) seen = 1;
         else begin
            @(negedge clk);
            lat++;
         end
      end
      if (!seen) timeout = 1;
      else begin
         r = (sel == 3) ? bus3.R : bus4.R;
         @(negedge clk);
         d = (sel == 3) ? bus3.done : bus4.done;
         pulse1 = !d;
      end
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      set_in(4, 1'b0, INF, '0);
      set_in(3, 1'b0, INF, '0);
      repeat (3) @(negedge clk);
      n_checks++; if (bus4.busy !== 1'b0) begin $display("FAIL reset_busy: got %b expected 0", bus4.busy); n_fail++; end
      n_checks++; if (bus4.done !== 1'b0) begin $display("FAIL reset_done: got %b expected 0", bus4.done); n_fail++; end
      n_checks++; if (bus4.R !== INF) begin $display("FAIL reset_R: got %h expected %h", bus4.R, INF); n_fail++; end
      Reset_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (bus4.busy !== 1'b0) begin $display("FAIL post_reset_busy: got %b expected 0", bus4.busy); n_fail++; end
   endtask

   task automatic test_k_zero();
      pt_v p;
      int  d0, a0;
      p = mkpt(1234, 4321);
      d0 = dbl_cnt; a0 = add_cnt;
      set_in(4, 1'b1, p, '0);
      @(negedge clk);
      set_in(4, 1'b0, p, '0);
      n_checks++; if (bus4.busy !== 1'b1 || bus4.done !== 1'b0) begin
         $display("FAIL kzero_cycle1: got busy=%b done=%b expected busy=1 done=0", bus4.busy, bus4.done); n_fail++; end
      @(negedge clk);
      n_checks++; if (bus4.done !== 1'b1) begin $display("FAIL kzero_done_latency: got %b expected 1", bus4.done); n_fail++; end
      n_checks++; if (bus4.R !== INF) begin $display("FAIL kzero_R: got %h expected %h", bus4.R, INF); n_fail++; end
      @(negedge clk);
      n_checks++; if (bus4.done !== 1'b0) begin $display("FAIL kzero_pulse: got %b expected 0", bus4.done); n_fail++; end
      n_checks++; if ((dbl_cnt - d0) + (add_cnt - a0) !== 0) begin
         $display("FAIL kzero_launches: got %0d expected 0", (dbl_cnt - d0) + (add_cnt - a0)); n_fail++; end
   endtask

   task automatic test_k_one();
      pt_v p, r;
      int  lat, d0, a0, exp_dbl, exp_add;
      bit  to, p1;
`ifdef PMUL_SKIP_LEADING_ZERO_EN
      exp_dbl = 1;   exp_add = 13;
`else
      exp_dbl = 257; exp_add = 14;
`endif
      p = mkpt(111, 222);
      d0 = dbl_cnt; a0 = add_cnt;
      run_op(4, p, SW'(1), r, lat, to, p1);
      n_checks++; if (to) begin $display("FAIL kone_timeout: got timeout expected done"); n_fail++; end
      n_checks++; if (r !== p) begin $display("FAIL kone_R: got %h expected %h", r, p); n_fail++; end
      n_checks++; if (dbl_cnt - d0 !== exp_dbl) begin $display("FAIL kone_doubles: got %0d expected %0d", dbl_cnt - d0, exp_dbl); n_fail++; end
      n_checks++; if (add_cnt - a0 !== exp_add) begin $display("FAIL kone_adds: got %0d expected %0d", add_cnt - a0, exp_add); n_fail++; end
      n_checks++; if (!p1) begin $display("FAIL kone_pulse: got wide done expected 1 cycle"); n_fail++; end
   endtask

   task automatic test_all_ones();
      pt_v p, r, e;
      logic [SW-1:0] k;
      int lat;
      bit to, p1;
      p = mkpt(65520, 3);
      k = '1;
      e = golden(k, p);
      run_op(4, p, k, r, lat, to, p1);
      n_checks++; if (to || r !== e) begin $display("FAIL ones_R: got %h expected %h", r, e); n_fail++; end
      n_checks++; if (!p1) begin $display("FAIL ones_pulse: got wide done expected 1 cycle"); n_fail++; end
   endtask

   task automatic test_random();
      pt_v p, r, e;
      logic [SW-1:0] k;
      int lat;
      bit to, p1;
      for (int i = 0; i < 50; i++) begin
         p = mkpt($urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1));
         k = rand_k();
         e = golden(k, p);
         run_op(4, p, k, r, lat, to, p1);
         n_checks++; if (to || r !== e || !p1) begin
            $display("FAIL random_%0d: got %h pulse1=%b expected %h pulse1=1", i, r, p1, e); n_fail++; end
      end
   endtask

   task automatic test_win3();
      pt_v p, r, e;
      logic [SW-1:0] kv [4];
      int lat;
      bit to, p1;
      kv[0] = '1; kv[1] = SW'(5); kv[2] = rand_k(); kv[3] = {1'b1, {(SW-1){1'b0}}};
      p = mkpt(40000, 12345);
      for (int i = 0; i < 4; i++) begin
         e = golden(kv[i], p);
         run_op(3, p, kv[i], r, lat, to, p1);
         n_checks++; if (to || r !== e) begin $display("FAIL win3_%0d: got %h expected %h", i, r, e); n_fail++; end
      end
   endtask

   task automatic test_back_to_back();
      pt_v p0, r, e;
      logic [SW-1:0] k0;
      int cyc, ndone;
      p0 = mkpt(777, 888);
      k0 = rand_k();
      e = golden(k0, p0);
      r = INF; ndone = 0; cyc = 0;
      set_in(4, 1'b1, p0, k0);
      @(negedge clk);
      while (bus4.busy && cyc < 5000) begin
         set_in(4, 1'b1, mkpt(cyc, 3 * cyc), rand_k());
         @(negedge clk);
         if (bus4.done) begin ndone++; r = bus4.R; end
         cyc++;
      end
      set_in(4, 1'b0, p0, k0);
      repeat (20) begin
         @(negedge clk);
         if (bus4.done) ndone++;
      end
      n_checks++; if (ndone !== 1) begin $display("FAIL b2b_done_count: got %0d expected 1", ndone); n_fail++; end
      n_checks++; if (r !== e) begin $display("FAIL b2b_R: got %h expected %h", r, e); n_fail++; end
   endtask

   task automatic test_reset_mid();
      pt_v p, r, e;
      int lat;
      bit to, p1;
      p = mkpt(4242, 999);
      set_in(4, 1'b1, p, rand_k());
      @(negedge clk);
      set_in(4, 1'b0, p, '0);
      repeat (60) @(negedge clk);
      n_checks++; if (bus4.busy !== 1'b1) begin $display("FAIL mid_busy_before: got %b expected 1", bus4.busy); n_fail++; end
      #2 Reset_n = 1'b0;
      #1;
      n_checks++; if (bus4.busy !== 1'b0) begin $display("FAIL mid_reset_busy: got %b expected 0", bus4.busy); n_fail++; end
      n_checks++; if (bus4.done !== 1'b0) begin $display("FAIL mid_reset_done: got %b expected 0", bus4.done); n_fail++; end
      n_checks++; if (bus4.R !== INF) begin $display("FAIL mid_reset_R: got %h expected %h", bus4.R, INF); n_fail++; end
      @(negedge clk);
      Reset_n = 1'b1;
      @(negedge clk);
      e = mkpt(21210, 4995);
      run_op(4, p, SW'(5), r, lat, to, p1);
      n_checks++; if (to || r !== e) begin $display("FAIL mid_rerun_R: got %h expected %h", r, e); n_fail++; end
   endtask

   initial begin
      test_reset();
      test_k_zero();
      test_k_one();
      test_all_ones();
      test_random();
      test_win3();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
